sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Parametrised controller for a single external asynchronous SRAM, shared by the instruction-fetch (IF) port and the execute/memory (EXE) port.
- EXE has strict priority over IF. Every SRAM cycle is timed by configurable wait states.
- Each port uses a req/done handshake.
- An optional one-entry fetch tag returns repeated IF reads without touching the SRAM; any EXE write to the tagged address invalidates the tag.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- RD_WAIT, 1, extra cycles sram_oe_n is held low before capture (0..15).
- WR_WAIT, 1, extra cycles sram_we_n is held low (0..15).
- IF_TAG_EN, 1, 1 enables the one-entry IF fetch tag; 0 sends every IF read to the SRAM.

Ports:
- clk  in  1  single clock domain; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  IF read request; held until if_done.
- if_addr  in  ADDR_W  IF read address.
- if_done  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DATA_W  IF read data; holds until the next IF completion.
- exe_req  in  1  EXE request; held until exe_done.
- exe_we  in  1  1 = write, 0 = read.
- exe_addr  in  ADDR_W  EXE address.
- exe_wdata  in  DATA_W  EXE write data.
- exe_done  out  1  one-cycle completion pulse.
- exe_rdata  out  DATA_W  EXE read data; holds until the next EXE read.
- sram_addr  out  ADDR_W  registered SRAM address.
- sram_data  inout  DATA_W  SRAM data bus; driven only in write states, else high-Z.
- sram_en_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state goes to IDLE; all strobes = 1; sram_data high-Z; sram_addr = 0.
  - if_done = exe_done = 0; if_rdata = exe_rdata = 0.
  - tag invalid; busy = 0.
  - Reset mid-operation aborts the access immediately. No done pulse is issued, and strobes are deasserted on that same edge.
- Arbitration (in IDLE only):
  - exe_req wins over if_req.
  - A request is granted in the cycle it is seen. sram_addr and the internal op/port are latched at the grant edge.
- States:
  - IDLE
  - RD: en_n = 0, oe_n = 0, for RD_WAIT+1 cycles. Data is captured on the last cycle's edge.
  - WR_SU: en_n = 0, data driven, we_n = 1, 1 cycle.
  - WR_PL: we_n = 0, WR_WAIT+1 cycles.
  - WR_HD: we_n = 1, data still driven, 1 cycle.
  - DONE: done pulse to the owning port, strobes high, 1 cycle, then IDLE.
- Read latency: grant edge → RD_WAIT+1 cycles in RD → DONE. Done is seen RD_WAIT+2 cycles after the request is first sampled.
- Write latency: WR_WAIT+4 cycles from request sample to exe_done.
- The wait counter loads at state entry and counts down to 0. Its width is ceil(log2(16)) = 4 bits.
- Requester rules:
  - The requester drops req or presents a new request in the cycle after done.
  - A req still high in IDLE after done is treated as a new request.
  - Address, we and wdata changes while busy are ignored.
- IF fetch tag (IF_TAG_EN=1):
  - Set on each SRAM IF read completion: tag = if_addr, data copy kept in if_rdata, valid = 1.
  - Hit condition in IDLE: if_req, no exe_req, valid, and if_addr == tag.
  - On a hit, if_done is asserted on the next cycle, the SRAM is untouched, and state stays IDLE.
  - An EXE write with exe_addr == tag clears valid at the grant edge.
  - An EXE read does not affect the tag.
- Simultaneous events:
  - exe_req and an if_req tag hit in the same cycle: the EXE access is granted; the IF hit waits.
  - exe_req arriving while busy on IF waits for DONE, then wins at the next IDLE.

Decomposition:
- Package sram_pkg:
  - state encoding localparams (IDLE, RD, WR_SU, WR_PL, WR_HD, DONE)
  - op encoding (OP_RD, OP_WR)
  - port-id encoding (PORT_IF, PORT_EXE)
  - wait-counter width constant
- One sub-module, sram_fetch_tag: tag register, valid bit, hit compare, invalidate-on-write. It is instantiated only when IF_TAG_EN = 1; otherwise its hit output is tied to 0.

Test Plan:
- EXE write at RD_WAIT = WR_WAIT = 1: exe_req=1, exe_we=1, addr=0x00010, wdata=0xBEEF.
  - Response: WR_SU, then WR_PL for 2 cycles with we_n = 0, then WR_HD; exe_done pulses exactly 5 cycles after the request.
  - Check: sram_data = 0xBEEF throughout WR_SU..WR_HD and high-Z otherwise.
- IF read then tag hit: model SRAM holds 0x1234 at 0x00020; if_req at addr 0x00020.
  - First access: if_done after 3 cycles, if_rdata = 0x1234.
  - Second identical request: if_done 1 cycle later, with oe_n never going low.
- Tag invalidation: after the hit above, EXE write 0x5678 to 0x00020, then IF read 0x00020.
  - Response: an SRAM RD cycle occurs and if_rdata = 0x5678.
- Priority: if_req and exe_req (read at 0x00030, which holds 0xAAAA) raised together.
  - Response: exe_done first with exe_rdata = 0xAAAA; if_done follows after the next full RD sequence.
- Reset mid-read: rst = 0 in the second RD cycle.
  - Response: next cycle state is IDLE, all strobes = 1, no done pulse.
  - After rst = 1, a fresh IF read of the same address goes to the SRAM (tag invalid).
- Wait sweep with RD_WAIT = 3, WR_WAIT = 0:
  - Read latency is 5 cycles with oe_n low for 4 cycles.
  - Write latency is 4 cycles with we_n low for 1 cycle.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared encodings for the SRAM arbiter.
//   state_t : controller FSM states
//   op_t    : latched operation of the current SRAM cycle
//   port_t  : port that owns the current SRAM cycle
//   CNT_W   : width of the wait-state down-counter (wait values 0..15)
package sram_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR_SU = 3'd2,
        ST_WR_PL = 3'd3,
        ST_WR_HD = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_EXE = 1'b1
    } port_t;

endpackage

// File: rtl/sram_fetch_tag.sv
// sram_fetch_tag: one-entry address tag for instruction fetches.
//   clk, rst      : clock, synchronous active-low reset
//   set, set_addr : record a completed SRAM IF read address, mark valid
//   inv, inv_addr : EXE write grant; clears valid when the address matches
//   lookup_addr   : current IF request address
//   hit           : valid tag equal to lookup_addr
// The data copy lives in the arbiter's if_rdata register, which only ever
// changes on IF completions, so only the address is held here.
module sram_fetch_tag #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              inv,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit
);

    logic [ADDR_W-1:0] tag_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (set) begin
            tag_q   <= set_addr;
            valid_q <= 1'b1;
        end else if (inv && (inv_addr == tag_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit = valid_q && (lookup_addr == tag_q);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between an IF read port and an
// EXE read/write port. EXE has strict priority; all SRAM cycles are timed by
// wait-state counters. Optional one-entry fetch tag serves repeated IF reads.
//   clk, rst                        : clock, synchronous active-low reset
//   if_req/if_addr                  : IF read request (held until if_done)
//   if_done/if_rdata                : IF completion pulse and read data
//   exe_req/exe_we/exe_addr/wdata   : EXE request (held until exe_done)
//   exe_done/exe_rdata              : EXE completion pulse and read data
//   sram_addr/sram_data             : registered address, bidirectional data
//   sram_en_n/sram_oe_n/sram_we_n   : active-low SRAM strobes
//   busy                            : high whenever the FSM is not IDLE
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | arbitrate; grant or answer an IF tag hit
// ST_RD    | en_n/oe_n low for RD_WAIT+1 cycles, capture on the last edge
// ST_WR_SU | en_n low, data driven, we_n high (setup)
// ST_WR_PL | we_n low for WR_WAIT+1 cycles
// ST_WR_HD | we_n high, data still driven (hold)
// ST_DONE  | done pulse to the owning port, strobes high
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int RD_WAIT   = 1,
    parameter int WR_WAIT   = 1,
    parameter bit IF_TAG_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              exe_req,
    input  logic              exe_we,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    output logic              exe_done,
    output logic [DATA_W-1:0] exe_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_en_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_t               op_q;
    port_t             port_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hit_q;
    logic              tag_hit;
    logic              grant_exe, grant_if, hit_now, capture;
    logic              wr_phase;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // hit_q marks the cycle in which a tag-hit if_done is shown; arbitration
    // pauses for that cycle so the still-high if_req is not served twice.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_exe = 1'b0;
        grant_if  = 1'b0;
        hit_now   = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hit_q) begin
                    if (exe_req) begin
                        grant_exe = 1'b1;
                        if (exe_we) begin
                            state_d = ST_WR_SU;
                        end else begin
                            state_d = ST_RD;
                            cnt_d   = CNT_W'(RD_WAIT);
                        end
                    end else if (if_req) begin
                        if (tag_hit) begin
                            hit_now = 1'b1;
                        end else begin
                            grant_if = 1'b1;
                            state_d  = ST_RD;
                            cnt_d    = CNT_W'(RD_WAIT);
                        end
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SU: begin
                state_d = ST_WR_PL;
                cnt_d   = CNT_W'(WR_WAIT);
            end
            ST_WR_PL: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_HD: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= OP_RD;
            port_q    <= PORT_IF;
            sram_addr <= '0;
            wdata_q   <= '0;
            if_rdata  <= '0;
            exe_rdata <= '0;
            hit_q     <= 1'b0;
        end else begin
            hit_q <= hit_now;
            if (grant_exe) begin
                op_q      <= exe_we ? OP_WR : OP_RD;
                port_q    <= PORT_EXE;
                sram_addr <= exe_addr;
                wdata_q   <= exe_wdata;
            end else if (grant_if) begin
                op_q      <= OP_RD;
                port_q    <= PORT_IF;
                sram_addr <= if_addr;
            end
            if (capture) begin
                if (port_q == PORT_IF) begin
                    if_rdata <= sram_data;
                end else begin
                    exe_rdata <= sram_data;
                end
            end
        end
    end

    generate
        if (IF_TAG_EN) begin : g_tag
            sram_fetch_tag #(
                .ADDR_W (ADDR_W)
            ) u_tag (
                .clk         (clk),
                .rst         (rst),
                .set         (capture && (port_q == PORT_IF)),
                .set_addr    (sram_addr),
                .inv         (grant_exe && exe_we),
                .inv_addr    (exe_addr),
                .lookup_addr (if_addr),
                .hit         (tag_hit)
            );
        end else begin : g_no_tag
            assign tag_hit = 1'b0;
        end
    endgenerate

    assign wr_phase  = (state_q == ST_WR_SU) || (state_q == ST_WR_PL) ||
                       (state_q == ST_WR_HD);
    assign sram_data = (wr_phase && (op_q == OP_WR)) ? wdata_q : 'z;

    assign sram_en_n = !(wr_phase || (state_q == ST_RD));
    assign sram_oe_n = (state_q != ST_RD);
    assign sram_we_n = (state_q != ST_WR_PL);
    assign busy      = (state_q != ST_IDLE);
    assign if_done   = ((state_q == ST_DONE) && (port_q == PORT_IF)) || hit_q;
    assign exe_done  = (state_q == ST_DONE) && (port_q == PORT_EXE);

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb_if[$];
    logic [DW-1:0] sb_exe[$];
    logic [DW-1:0] exp_v;

    // ---------------- instance A: RD_WAIT=1, WR_WAIT=1 ----------------
    logic          if_req = 1'b0, exe_req = 1'b0, exe_we = 1'b0;
    logic [AW-1:0] if_addr = '0, exe_addr = '0;
    logic [DW-1:0] exe_wdata = '0;
    wire           if_done, exe_done, busy, en_n, oe_n, we_n;
    wire  [DW-1:0] if_rdata, exe_rdata;
    wire  [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic [DW-1:0] mem [0:255];

    assign sram_data = (!en_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 'z;
    always @(posedge clk) if (!en_n && !we_n) mem[sram_addr[7:0]] = sram_data;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1), .WR_WAIT(1), .IF_TAG_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .exe_req(exe_req), .exe_we(exe_we), .exe_addr(exe_addr), .exe_wdata(exe_wdata),
        .exe_done(exe_done), .exe_rdata(exe_rdata),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_en_n(en_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .busy(busy)
    );

    // ---------------- instance W: RD_WAIT=3, WR_WAIT=0 ----------------
    logic          if_req_w = 1'b0, exe_req_w = 1'b0, exe_we_w = 1'b0;
    logic [AW-1:0] if_addr_w = '0, exe_addr_w = '0;
    logic [DW-1:0] exe_wdata_w = '0;
    wire           if_done_w, exe_done_w, busy_w, en_n_w, oe_n_w, we_n_w;
    wire  [DW-1:0] if_rdata_w, exe_rdata_w;
    wire  [AW-1:0] sram_addr_w;
    wire  [DW-1:0] sram_data_w;
    logic [DW-1:0] mem_w [0:255];

    assign sram_data_w = (!en_n_w && !oe_n_w && we_n_w) ? mem_w[sram_addr_w[7:0]] : 'z;
    always @(posedge clk) if (!en_n_w && !we_n_w) mem_w[sram_addr_w[7:0]] = sram_data_w;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(3), .WR_WAIT(0), .IF_TAG_EN(1)) u_wt (
        .clk(clk), .rst(rst),
        .if_req(if_req_w), .if_addr(if_addr_w), .if_done(if_done_w), .if_rdata(if_rdata_w),
        .exe_req(exe_req_w), .exe_we(exe_we_w), .exe_addr(exe_addr_w), .exe_wdata(exe_wdata_w),
        .exe_done(exe_done_w), .exe_rdata(exe_rdata_w),
        .sram_addr(sram_addr_w), .sram_data(sram_data_w),
        .sram_en_n(en_n_w), .sram_oe_n(oe_n_w), .sram_we_n(we_n_w), .busy(busy_w)
    );

    // Observes one instance from the request edge until the selected done
    // pulse (bounded). Called just after a negedge; returns on the negedge
    // where done is seen. n counts rising edges from the request sample.
    task automatic wait_done(input bit wt, input bit exe_port, input logic [DW-1:0] wd,
                             output int n, output int oe_lo, output int we_lo,
                             output int en_wr, output int bad, output int other);
        bit got;
        got = 1'b0; n = 0; oe_lo = 0; we_lo = 0; en_wr = 0; bad = 0; other = 0;
        while (!got && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!wt) begin
                if (!oe_n) oe_lo++;
                if (!we_n) we_lo++;
                if (!en_n && oe_n) begin
                    en_wr++;
                    if (sram_data !== wd) bad++;
                end
                got = exe_port ? exe_done : if_done;
                if (exe_port ? if_done : exe_done) other++;
            end else begin
                if (!oe_n_w) oe_lo++;
                if (!we_n_w) we_lo++;
                if (!en_n_w && oe_n_w) begin
                    en_wr++;
                    if (sram_data_w !== wd) bad++;
                end
                got = exe_port ? exe_done_w : if_done_w;
                if (exe_port ? if_done_w : exe_done_w) other++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({en_n, oe_n, we_n} !== 3'b111) begin
            failures++; $display("FAIL reset_strobes: got %b want 111", {en_n, oe_n, we_n});
        end
        checks++;
        if ({busy, if_done, exe_done} !== 3'b000) begin
            failures++; $display("FAIL reset_busy_done: got %b want 000", {busy, if_done, exe_done});
        end
        checks++;
        if (if_rdata !== 16'h0 || exe_rdata !== 16'h0 || sram_addr !== 18'h0) begin
            failures++;
            $display("FAIL reset_regs: got if=%h exe=%h addr=%h want 0", if_rdata, exe_rdata, sram_addr);
        end
        checks++;
        if ({busy_w, en_n_w, oe_n_w, we_n_w} !== 4'b0111) begin
            failures++; $display("FAIL reset_wt: got %b want 0111", {busy_w, en_n_w, oe_n_w, we_n_w});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exe_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n, oe_lo, we_lo, en_wr, bad, other;
        exe_req = 1'b1; exe_we = 1'b1; exe_addr = a; exe_wdata = d;
        wait_done(1'b0, 1'b1, d, n, oe_lo, we_lo, en_wr, bad, other);
        exe_req = 1'b0; exe_we = 1'b0;
        checks++;
        if (n !== 5) begin failures++; $display("FAIL wr_latency: got %0d want 5", n); end
        checks++;
        if (we_lo !== 2 || oe_lo !== 0) begin
            failures++; $display("FAIL wr_strobes: got we_lo=%0d oe_lo=%0d want 2 0", we_lo, oe_lo);
        end
        checks++;
        if (en_wr !== 4 || bad !== 0) begin
            failures++; $display("FAIL wr_bus: got drive_cycles=%0d bad=%0d want 4 0", en_wr, bad);
        end
        checks++;
        if (mem[a[7:0]] !== d) begin
            failures++; $display("FAIL wr_mem: got %h want %h", mem[a[7:0]], d);
        end
        @(negedge clk);
    endtask

    task automatic test_if_tag();
        int n, oe_lo, we_lo, en_wr, bad, other;
        if_req = 1'b1; if_addr = 18'h00020; sb_if.push_back(16'h1234);
        wait_done(1'b0, 1'b0, 16'h0, n, oe_lo, we_lo, en_wr, bad, other);
        if_req = 1'b0;
        checks++;
        if (n !== 3 || oe_lo !== 2) begin
            failures++; $display("FAIL if_miss_timing: got n=%0d oe_lo=%0d want 3 2", n, oe_lo);
        end
        exp_v = sb_if.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin failures++; $display("FAIL if_miss_data: got %h want %h", if_rdata, exp_v); end
        @(negedge clk);
        if_req = 1'b1; sb_if.push_back(16'h1234);
        wait_done(1'b0, 1'b0, 16'h0, n, oe_lo, we_lo, en_wr, bad, other);
        if_req = 1'b0;
        checks++;
        if (n !== 1 || oe_lo !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL if_hit_timing: got n=%0d oe_lo=%0d busy=%b want 1 0 0", n, oe_lo, busy);
        end
        exp_v = sb_if.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin failures++; $display("FAIL if_hit_data: got %h want %h", if_rdata, exp_v); end
        @(negedge clk);
        checks++;
        if (if_done !== 1'b0) begin failures++; $display("FAIL if_hit_single: got %b want 0", if_done); end
    endtask

    task automatic test_tag_inval();
        int n, oe_lo, we_lo, en_wr, bad, other;
        test_exe_write(18'h00020, 16'h5678);
        if_req = 1'b1; if_addr = 18'h00020; sb_if.push_back(16'h5678);
        wait_done(1'b0, 1'b0, 16'h0, n, oe_lo, we_lo, en_wr, bad, other);
        if_req = 1'b0;
        checks++;
        if (n !== 3 || oe_lo !== 2) begin
            failures++; $display("FAIL inval_timing: got n=%0d oe_lo=%0d want 3 2", n, oe_lo);
        end
        exp_v = sb_if.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin failures++; $display("FAIL inval_data: got %h want %h", if_rdata, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_priority();
        int n, oe_lo, we_lo, en_wr, bad, other;
        exe_req = 1'b1; exe_we = 1'b0; exe_addr = 18'h00030; sb_exe.push_back(16'hAAAA);
        if_req = 1'b1; if_addr = 18'h00050; sb_if.push_back(16'h1111);
        wait_done(1'b0, 1'b1, 16'h0, n, oe_lo, we_lo, en_wr, bad, other);
        exe_req = 1'b0;
        checks++;
        if (n !== 3 || other !== 0) begin
            failures++; $display("FAIL prio_exe_first: got n=%0d if_done_seen=%0d want 3 0", n, other);
        end
        exp_v = sb_exe.pop_front();
        checks++;
        if (exe_rdata !== exp_v) begin failures++; $display("FAIL prio_exe_data: got %h want %h", exe_rdata, exp_v); end
        wait_done(1'b0, 1'b0, 16'h0, n, oe_lo, we_lo, en_wr, bad, other);
        if_req = 1'b0;
        checks++;
        if (n !== 4 || oe_lo !== 2 || other !== 0) begin
            failures++; $display("FAIL prio_if_after: got n=%0d oe_lo=%0d extra=%0d want 4 2 0", n, oe_lo, other);
        end
        exp_v = sb_if.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin failures++; $display("FAIL prio_if_data: got %h want %h", if_rdata, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int n, oe_lo, we_lo, en_wr, bad, other;
        // tag currently holds 0x50; start a read elsewhere and abort it
        if_req = 1'b1; if_addr = 18'h00060;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++;
        if (oe_n !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL rst_mid_inread: got oe_n=%b busy=%b want 0 1", oe_n, busy);
        end
        rst = 1'b0; if_req = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({busy, en_n, oe_n, we_n, if_done, exe_done} !== 6'b011100) begin
            failures++;
            $display("FAIL rst_mid_abort: got %b want 011100", {busy, en_n, oe_n, we_n, if_done, exe_done});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (if_done !== 1'b0 || if_rdata !== 16'h0) begin
            failures++; $display("FAIL rst_mid_after: got done=%b rdata=%h want 0 0000", if_done, if_rdata);
        end
        if_req = 1'b1; if_addr = 18'h00050; sb_if.push_back(16'h1111);
        wait_done(1'b0, 1'b0, 16'h0, n, oe_lo, we_lo, en_wr, bad, other);
        if_req = 1'b0;
        checks++;
        if (n !== 3 || oe_lo !== 2) begin
            failures++; $display("FAIL rst_tag_cleared: got n=%0d oe_lo=%0d want 3 2", n, oe_lo);
        end
        exp_v = sb_if.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin failures++; $display("FAIL rst_reread_data: got %h want %h", if_rdata, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_wait_sweep();
        int n, oe_lo, we_lo, en_wr, bad, other;
        if_req_w = 1'b1; if_addr_w = 18'h00008; sb_if.push_back(16'hC0DE);
        wait_done(1'b1, 1'b0, 16'h0, n, oe_lo, we_lo, en_wr, bad, other);
        if_req_w = 1'b0;
        checks++;
        if (n !== 5 || oe_lo !== 4) begin
            failures++; $display("FAIL sweep_rd: got n=%0d oe_lo=%0d want 5 4", n, oe_lo);
        end
        exp_v = sb_if.pop_front();
        checks++;
        if (if_rdata_w !== exp_v) begin failures++; $display("FAIL sweep_rd_data: got %h want %h", if_rdata_w, exp_v); end
        @(negedge clk);
        exe_req_w = 1'b1; exe_we_w = 1'b1; exe_addr_w = 18'h00009; exe_wdata_w = 16'h7777;
        wait_done(1'b1, 1'b1, 16'h7777, n, oe_lo, we_lo, en_wr, bad, other);
        exe_req_w = 1'b0; exe_we_w = 1'b0;
        checks++;
        if (n !== 4 || we_lo !== 1) begin
            failures++; $display("FAIL sweep_wr: got n=%0d we_lo=%0d want 4 1", n, we_lo);
        end
        checks++;
        if (en_wr !== 3 || bad !== 0 || mem_w[9] !== 16'h7777) begin
            failures++;
            $display("FAIL sweep_wr_bus: got cycles=%0d bad=%0d mem=%h want 3 0 7777", en_wr, bad, mem_w[9]);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 16'(i * 3);
            mem_w[i] = 16'(i * 5);
        end
        mem[8'h20]   = 16'h1234;
        mem[8'h30]   = 16'hAAAA;
        mem[8'h50]   = 16'h1111;
        mem[8'h60]   = 16'h2222;
        mem_w[8'h08] = 16'hC0DE;

        test_reset();
        test_exe_write(18'h00010, 16'hBEEF);
        test_if_tag();
        test_tag_inval();
        test_priority();
        test_reset_mid_read();
        test_wait_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
